// File: rtl/alu_uart_intf_if.sv
// alu_uart_intf_if
// Bundles the byte-stream handshake between the UART receiver/transmitter,
// the combinational ALU and the alu_uart_intf front end.
//
// Parameters:
//   N_BITS : width of received bytes, operands, result and transmit byte
//   N_OP   : opcode width
//
// Signals (directions seen from the front end, i.e. the slave modport):
//   i_rx_data    in   received byte, valid while i_rx_done is high
//   i_rx_done    in   one-cycle "byte available" pulse from the receiver
//   i_alu_result in   combinational ALU output
//   i_tx_done    in   one-cycle "frame sent" pulse from the transmitter
//   o_alu_a      out  operand A to the ALU
//   o_alu_b      out  operand B to the ALU
//   o_alu_op     out  opcode to the ALU
//   o_tx_data    out  result byte to the transmitter
//   o_tx_start   out  one-cycle transmit request
//   o_busy       out  high while a result is being produced or sent
interface alu_uart_intf_if #(
    parameter int N_BITS = 8,
    parameter int N_OP   = 6
);
    logic [N_BITS-1:0] i_rx_data;
    logic              i_rx_done;
    logic [N_BITS-1:0] i_alu_result;
    logic              i_tx_done;
    logic [N_BITS-1:0] o_alu_a;
    logic [N_BITS-1:0] o_alu_b;
    logic [N_OP-1:0]   o_alu_op;
    logic [N_BITS-1:0] o_tx_data;
    logic              o_tx_start;
    logic              o_busy;

    // The environment side: UART blocks and ALU drive the inputs.
    modport master (
        output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
        input  o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy
    );

    // The front end itself.
    modport slave (
        input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
        output o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy
    );
endinterface

// File: rtl/alu_uart_intf.sv
// alu_uart_intf
// Byte-stream front end for the ALU. Collects operand A, operand B and the
// opcode from three received bytes, lets the ALU settle for one cycle,
// captures its result and requests transmission with a one-cycle pulse.
//
// Ports:
//   clock  single clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    alu_uart_intf_if.slave (rx/tx handshake, ALU operands/result)
//
// Parameters:
//   N_BITS         data width (bytes, operands, result)
//   N_OP           opcode width, taken from the low bits of the third byte
//   TIMEOUT_CYCLES inter-byte timeout in cycles (only with the macro below)
//
// Optional feature:
//   ALU_INTF_TIMEOUT_EN  when defined, a partially received operand set is
//                        abandoned after TIMEOUT_CYCLES idle cycles in
//                        WAIT_B/WAIT_OP. When undefined, those states wait
//                        forever and no counter exists.
module alu_uart_intf #(
    parameter int N_BITS         = 8,
    parameter int N_OP           = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input logic           clock,
    input logic           reset,
    alu_uart_intf_if.slave bus
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    state_t            state;
    logic [N_BITS-1:0] alu_a;
    logic [N_BITS-1:0] alu_b;
    logic [N_OP-1:0]   alu_op;
    logic [N_BITS-1:0] tx_data;
    logic              tx_start;
    logic              busy;

`ifdef ALU_INTF_TIMEOUT_EN
    // A width of at least one bit keeps degenerate timeouts elaborating.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] idle_cnt;
`endif

    // Single-process Moore FSM. tx_start and busy are registered from the
    // state being entered, so they line up with the state register.
    // The idle counter defaults to zero every cycle and only counts while
    // waiting for the second or third byte with nothing arriving.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= WAIT_A;
            alu_a    <= {N_BITS{1'b0}};
            alu_b    <= {N_BITS{1'b0}};
            alu_op   <= {N_OP{1'b0}};
            tx_data  <= {N_BITS{1'b0}};
            tx_start <= 1'b0;
            busy     <= 1'b0;
`ifdef ALU_INTF_TIMEOUT_EN
            idle_cnt <= '0;
`endif
        end else begin
`ifdef ALU_INTF_TIMEOUT_EN
            idle_cnt <= '0;
`endif
            case (state)
                WAIT_A: begin
                    if (bus.i_rx_done) begin
                        alu_a <= bus.i_rx_data;
                        state <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (bus.i_rx_done) begin
                        alu_b <= bus.i_rx_data;
                        state <= WAIT_OP;
                    end
`ifdef ALU_INTF_TIMEOUT_EN
                    else if (idle_cnt == CNT_MAX) begin
                        state <= WAIT_A;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
`endif
                end
                WAIT_OP: begin
                    if (bus.i_rx_done) begin
                        alu_op <= bus.i_rx_data[N_OP-1:0];
                        state  <= EXEC;
                        busy   <= 1'b1;
                    end
`ifdef ALU_INTF_TIMEOUT_EN
                    else if (idle_cnt == CNT_MAX) begin
                        state <= WAIT_A;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
`endif
                end
                EXEC: begin
                    // Operands were registered last edge, so the ALU output
                    // has had a full cycle to settle.
                    tx_data  <= bus.i_alu_result;
                    tx_start <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    tx_start <= 1'b0;
                    state    <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (bus.i_tx_done) begin
                        busy  <= 1'b0;
                        state <= WAIT_A;
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    busy     <= 1'b0;
                    state    <= WAIT_A;
                end
            endcase
        end
    end

    assign bus.o_alu_a    = alu_a;
    assign bus.o_alu_b    = alu_b;
    assign bus.o_alu_op   = alu_op;
    assign bus.o_tx_data  = tx_data;
    assign bus.o_tx_start = tx_start;
    assign bus.o_busy     = busy;

endmodule

// File: tb/tb_alu_uart_intf.sv
// tb_alu_uart_intf
// Self-checking bench for alu_uart_intf. A small ALU model drives the
// result input; expected operands, opcode and transmitted byte are tracked
// at transaction level from the bytes the bench sends.
// Honors ALU_INTF_TIMEOUT_EN to choose the matching timeout scenario.
module tb_alu_uart_intf;

    localparam int N_BITS         = 8;
    localparam int N_OP           = 6;
    localparam int TIMEOUT_CYCLES = 16;

    logic clock = 1'b0;
    logic reset;

    int check_count  = 0;
    int error_count  = 0;
    int start_pulses = 0;

    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic [5:0] exp_op;

    alu_uart_intf_if #(.N_BITS(N_BITS), .N_OP(N_OP)) bus ();

    alu_uart_intf #(
        .N_BITS(N_BITS),
        .N_OP(N_OP),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    // Reference ALU: a handful of TP2 operations, everything else yields 0.
    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h03:   return 8'($signed(a) >>> b[2:0]);
            6'h02:   return a >> b[2:0];
            default: return 8'h00;
        endcase
    endfunction

    assign bus.i_alu_result = alu_model(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);

    // Count transmit requests seen at each rising edge.
    always @(posedge clock) begin
        if (bus.o_tx_start === 1'b1) start_pulses++;
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One receiver byte pulse; starts and ends on a falling edge.
    task automatic apply_stimulus(input logic [7:0] data);
        bus.i_rx_data = data;
        bus.i_rx_done = 1'b1;
        @(negedge clock);
        bus.i_rx_done = 1'b0;
        bus.i_rx_data = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_tx_done(input logic with_rx);
        bus.i_tx_done = 1'b1;
        bus.i_rx_done = with_rx;
        bus.i_rx_data = 8'h7F;
        @(negedge clock);
        bus.i_tx_done = 1'b0;
        bus.i_rx_done = 1'b0;
    endtask

    // Full request/response. With inject set, stray bytes arrive during
    // EXEC, SEND, WAIT_TX and alongside i_tx_done; all must be dropped.
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] opbyte, input logic inject);
        int pulses_before;
        logic [7:0] exp_tx;
        apply_stimulus(a);
        exp_a = a;
        check_output("load_a", bus.o_alu_a, exp_a);
        if ($urandom_range(0, 3) == 0) begin
            pulse_tx_done(1'b0);
            check_output("stray_txdone_busy", bus.o_busy, 1'b0);
        end
        idle($urandom_range(0, 2));
        apply_stimulus(b);
        exp_b = b;
        check_output("load_b", bus.o_alu_b, exp_b);
        check_output("hold_a", bus.o_alu_a, exp_a);
        idle($urandom_range(0, 2));
        pulses_before = start_pulses;
        apply_stimulus(opbyte);
        exp_op = opbyte[5:0];
        exp_tx = alu_model(exp_a, exp_b, exp_op);
        check_output("load_op", bus.o_alu_op, exp_op);
        check_output("exec_busy", bus.o_busy, 1'b1);
        check_output("exec_nostart", bus.o_tx_start, 1'b0);
        bus.i_rx_done = inject;
        bus.i_rx_data = 8'h7F;
        @(negedge clock);
        check_output("send_start", bus.o_tx_start, 1'b1);
        check_output("send_data", bus.o_tx_data, exp_tx);
        @(negedge clock);
        check_output("waittx_start_low", bus.o_tx_start, 1'b0);
        check_output("waittx_busy", bus.o_busy, 1'b1);
        idle($urandom_range(0, 3));
        pulse_tx_done(inject);
        check_output("done_idle", bus.o_busy, 1'b0);
        check_output("keep_a", bus.o_alu_a, exp_a);
        check_output("keep_b", bus.o_alu_b, exp_b);
        check_output("keep_op", bus.o_alu_op, exp_op);
        check_output("start_count", start_pulses - pulses_before, 1);
    endtask

    initial begin
        logic [5:0] ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};
        logic [7:0] opb;
        reset         = 1'b1;
        bus.i_rx_data = 8'h00;
        bus.i_rx_done = 1'b0;
        bus.i_tx_done = 1'b0;
        idle(2);
        check_output("rst_a", bus.o_alu_a, 0);
        check_output("rst_b", bus.o_alu_b, 0);
        check_output("rst_op", bus.o_alu_op, 0);
        check_output("rst_tx", bus.o_tx_data, 0);
        check_output("rst_start", bus.o_tx_start, 0);
        check_output("rst_busy", bus.o_busy, 0);
        reset = 1'b0;
        idle(1);

        // ADD
        run_txn(8'h05, 8'h03, 8'h20, 1'b0);
        check_output("add_op", bus.o_alu_op, 8'h20);
        check_output("add_tx", bus.o_tx_data, 8'h08);

        // SUB with opcode masking
        run_txn(8'h0A, 8'h04, 8'hE2, 1'b0);
        check_output("sub_op", bus.o_alu_op, 8'h22);
        check_output("sub_tx", bus.o_tx_data, 8'h06);

        // Dropped bytes while busy, then next byte loads A
        run_txn(8'h33, 8'h11, 8'h25, 1'b1);
        run_txn(8'h01, 8'h02, 8'h20, 1'b0);

        // Asynchronous reset in WAIT_TX, checked before any clock edge
        apply_stimulus(8'h12);
        apply_stimulus(8'h34);
        apply_stimulus(8'h20);
        idle(3);
        #2 reset = 1'b1;
        #1;
        check_output("async_rst_a", bus.o_alu_a, 0);
        check_output("async_rst_b", bus.o_alu_b, 0);
        check_output("async_rst_op", bus.o_alu_op, 0);
        check_output("async_rst_tx", bus.o_tx_data, 0);
        check_output("async_rst_start", bus.o_tx_start, 0);
        check_output("async_rst_busy", bus.o_busy, 0);
        @(negedge clock);
        reset = 1'b0;
        run_txn(8'h11, 8'h22, 8'h26, 1'b0);

        // Randomized transactions
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 4) == 0) opb = 8'($urandom);
            else opb = {2'($urandom), ops[$urandom_range(0, 7)]};
            run_txn(8'($urandom), 8'($urandom), opb, 1'($urandom));
        end

`ifdef ALU_INTF_TIMEOUT_EN
        apply_stimulus(8'h05);
        check_output("to_load_a", bus.o_alu_a, 8'h05);
        idle(TIMEOUT_CYCLES);
        check_output("to_busy", bus.o_busy, 0);
        check_output("to_keep_a", bus.o_alu_a, 8'h05);
        run_txn(8'h02, 8'h03, 8'h24, 1'b0);
        check_output("to_tx", bus.o_tx_data, 8'h02);
`else
        apply_stimulus(8'h05);
        check_output("noto_load_a", bus.o_alu_a, 8'h05);
        idle(10000);
        check_output("noto_busy", bus.o_busy, 0);
        apply_stimulus(8'h03);
        check_output("noto_load_b", bus.o_alu_b, 8'h03);
        check_output("noto_keep_a", bus.o_alu_a, 8'h05);
        apply_stimulus(8'h24);
        check_output("noto_op", bus.o_alu_op, 8'h24);
        idle(2);
        check_output("noto_tx", bus.o_tx_data, 8'h01);
        pulse_tx_done(1'b0);
        check_output("noto_done", bus.o_busy, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
